// File: rtl/burst_arbiter_pkg.sv
// Shared types and helpers for the burst arbiter.
//   state_t   : arbiter FSM states (IDLE, BUSY)
//   idx_width : width of a requester index (1 when n == 1, else clog2(n))
package burst_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin winner search: first set request bit at or after (last+1) mod N,
// searching upward with wrap-around. Purely combinational.
// Ports:
//   req   : request vector, one bit per requester
//   last  : index of the previous winner
//   grant : one-hot winner, all-zero when no request is set
//   idx   : index of the winner (0 when no request is set)
module rr_select
    import burst_arbiter_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic        found;
    int unsigned cand;

    // Walk candidates in priority order; the first requesting one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last) + k) % N;
            for (int unsigned j = 0; j < N; j++) begin
                if (!found && req[j] && (j == cand)) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    idx      = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/burst_arbiter.sv
// Round-robin burst arbiter: merges N valid/ready beat streams onto one output,
// locking the grant for a whole burst (until a transferred beat with last=1).
// Ports:
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_valid/i_data/i_last: per-requester beat inputs (data packed k-major)
//   o_ready              : per-requester beat accepted
//   o_valid/o_data/o_last: merged output stream, i_ready is downstream ready
//   o_grant              : one-hot owner of the output, zero when idle
//   o_busy               : a burst currently owns the output
module burst_arbiter
    import burst_arbiter_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N-1:0]            i_valid,
    output logic [N-1:0]            o_ready,
    input  logic [N*DATA_WIDTH-1:0] i_data,
    input  logic [N-1:0]            i_last,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_last,
    output logic [N-1:0]            o_grant,
    output logic                    o_busy
);

    localparam int unsigned   IW       = idx_width(N);
    // Reset to N-1 so that requester 0 is first in line after reset.
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

    state_t        state, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic [N-1:0]  sel_grant;
    logic [IW-1:0] sel_idx;

    rr_select #(
        .N  (N),
        .IW (IW)
    ) u_rr_select (
        .req   (i_valid),
        .last  (last_q),
        .grant (sel_grant),
        .idx   (sel_idx)
    );

    // State, grant and last-winner registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
        end else begin
            state   <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic and combinational mux of the granted stream.
    always_comb begin
        state_d = state;
        grant_d = grant_q;
        last_d  = last_q;
        o_valid = 1'b0;
        o_ready = '0;
        o_data  = '0;
        o_last  = 1'b0;
        o_grant = '0;
        o_busy  = 1'b0;
        case (state)
            IDLE: begin
                if (|i_valid) begin
                    state_d = BUSY;
                    grant_d = sel_grant;
                    last_d  = sel_idx;
                end
            end
            BUSY: begin
                o_busy  = 1'b1;
                o_grant = grant_q;
                o_ready = grant_q & {N{i_ready}};
                for (int k = 0; k < int'(N); k++) begin
                    if (grant_q[k]) begin
                        o_valid = i_valid[k];
                        o_data  = i_data[k*DATA_WIDTH +: DATA_WIDTH];
                        o_last  = i_last[k];
                    end
                end
                // Final beat transferring: release the output this edge.
                if (o_valid && i_ready && o_last) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

endmodule
